// File: rtl/id_ex_control_pipe.sv
// ID-stage decoder and ID/EX control register with load-use hazard detection, bubble/hold/flush.
// Optional ex_illegal output is compiled in when ILLEGAL_INSTR_EN is defined.
module id_ex_control_pipe #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     id_instr,
    input  logic            id_valid,
    input  logic            hold,
    input  logic            flush,
    output logic            stall_req,
    output logic            ex_valid,
    output logic [1:0]      ex_alu_op,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7,
    output logic            ex_alu_src,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_reg_write,
    output logic            ex_mem_to_reg,
    output logic            ex_branch,
    output logic [RA_W-1:0] ex_rs1,
    output logic [RA_W-1:0] ex_rs2,
    output logic [RA_W-1:0] ex_rd,
    output logic [XLEN-1:0] ex_imm
`ifdef ILLEGAL_INSTR_EN
    ,
    output logic            ex_illegal
`endif
);

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef struct packed {
        logic            valid;
        logic [1:0]      alu_op;
        logic [2:0]      funct3;
        logic            funct7;
        logic            alu_src;
        logic            mem_read;
        logic            mem_write;
        logic            reg_write;
        logic            mem_to_reg;
        logic            branch;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic [XLEN-1:0] imm;
    } ctrl_t;

    ctrl_t       dec;
    ctrl_t       ex_q;
    logic        legal;
    logic        uses_rs2;
    logic        hazard;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;

    assign imm_i = {{20{id_instr[31]}}, id_instr[31:20]};
    assign imm_s = {{20{id_instr[31]}}, id_instr[31:25], id_instr[11:7]};
    assign imm_b = {{19{id_instr[31]}}, id_instr[31], id_instr[7], id_instr[30:25],
                    id_instr[11:8], 1'b0};

    // Register fields an opcode does not use are zeroed so EX never sees stale indices.
    always_comb begin
        dec      = '0;
        legal    = 1'b0;
        uses_rs2 = 1'b0;
        case (id_instr[6:0])
            OP_R: begin
                legal         = 1'b1;
                uses_rs2      = 1'b1;
                dec.alu_op    = 2'b10;
                dec.reg_write = 1'b1;
                dec.funct7    = id_instr[30];
                dec.rs2       = RA_W'(id_instr[24:20]);
                dec.rd        = RA_W'(id_instr[11:7]);
            end
            OP_I: begin
                legal         = 1'b1;
                dec.alu_op    = 2'b10;
                dec.alu_src   = 1'b1;
                dec.reg_write = 1'b1;
                dec.rd        = RA_W'(id_instr[11:7]);
                dec.imm       = XLEN'($signed(imm_i));
            end
            OP_LW: begin
                legal          = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_read   = 1'b1;
                dec.reg_write  = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.rd         = RA_W'(id_instr[11:7]);
                dec.imm        = XLEN'($signed(imm_i));
            end
            OP_SW: begin
                legal         = 1'b1;
                uses_rs2      = 1'b1;
                dec.alu_src   = 1'b1;
                dec.mem_write = 1'b1;
                dec.rs2       = RA_W'(id_instr[24:20]);
                dec.imm       = XLEN'($signed(imm_s));
            end
            OP_BEQ: begin
                legal      = 1'b1;
                uses_rs2   = 1'b1;
                dec.alu_op = 2'b01;
                dec.branch = 1'b1;
                dec.rs2    = RA_W'(id_instr[24:20]);
                dec.imm    = XLEN'($signed(imm_b));
            end
            default: ;
        endcase
        if (legal) begin
            dec.funct3 = id_instr[14:12];
            dec.rs1    = RA_W'(id_instr[19:15]);
        end
        dec.valid = id_valid & legal;
    end

    assign hazard = ex_q.valid & ex_q.mem_read & (ex_q.rd != '0) &
                    ((ex_q.rd == dec.rs1) | (uses_rs2 & (ex_q.rd == dec.rs2)));

    assign stall_req = id_valid & legal & hazard & ~flush;

    // Flush outranks hold so a taken branch always squashes the younger instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q <= '0;
        end else if (flush) begin
            ex_q <= '0;
        end else if (hold) begin
            ex_q <= ex_q;
        end else if (stall_req) begin
            ex_q <= '0;
        end else begin
            ex_q <= dec;
        end
    end

`ifdef ILLEGAL_INSTR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_illegal <= 1'b0;
        end else if (flush) begin
            ex_illegal <= 1'b0;
        end else if (hold) begin
            ex_illegal <= ex_illegal;
        end else if (stall_req) begin
            ex_illegal <= 1'b0;
        end else begin
            ex_illegal <= id_valid & ~legal;
        end
    end
`endif

    assign ex_valid      = ex_q.valid;
    assign ex_alu_op     = ex_q.alu_op;
    assign ex_funct3     = ex_q.funct3;
    assign ex_funct7     = ex_q.funct7;
    assign ex_alu_src    = ex_q.alu_src;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_branch     = ex_q.branch;
    assign ex_rs1        = ex_q.rs1;
    assign ex_rs2        = ex_q.rs2;
    assign ex_rd         = ex_q.rd;
    assign ex_imm        = ex_q.imm;

endmodule

// File: tb/tb_id_ex_control_pipe.sv
// Self-checking bench for id_ex_control_pipe: directed spec vectors plus randomized traffic
// checked against an instruction-level reference model.
module tb_id_ex_control_pipe;

    logic        clk;
    logic        rst;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        hold;
    logic        flush;
    logic        stall_req;
    logic        ex_valid;
    logic [1:0]  ex_alu_op;
    logic [2:0]  ex_funct3;
    logic        ex_funct7;
    logic        ex_alu_src;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic        ex_branch;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic [31:0] ex_imm;
`ifdef ILLEGAL_INSTR_EN
    logic        ex_illegal;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic [59:0] obs;
    logic [59:0] m_vec;
    logic        m_ill;

    id_ex_control_pipe #(.XLEN(32), .RA_W(5)) dut (
        .clk(clk), .rst(rst), .id_instr(id_instr), .id_valid(id_valid), .hold(hold),
        .flush(flush), .stall_req(stall_req), .ex_valid(ex_valid), .ex_alu_op(ex_alu_op),
        .ex_funct3(ex_funct3), .ex_funct7(ex_funct7), .ex_alu_src(ex_alu_src),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_reg_write(ex_reg_write),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_branch(ex_branch), .ex_rs1(ex_rs1),
        .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm)
`ifdef ILLEGAL_INSTR_EN
        , .ex_illegal(ex_illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {ex_valid, ex_alu_op, ex_funct3, ex_funct7, ex_alu_src, ex_mem_read,
                  ex_mem_write, ex_reg_write, ex_mem_to_reg, ex_branch, ex_rs1, ex_rs2,
                  ex_rd, ex_imm};

    // Layout: valid, alu_op, funct3, funct7, {alu_src,mem_read,mem_write,reg_write,mem_to_reg,branch},
    // rs1, rs2, rd, imm
    function automatic logic model_legal(input logic [31:0] ins);
        int op;
        op = int'(ins[6:0]);
        return (op == 'h33) || (op == 'h13) || (op == 'h03) || (op == 'h23) || (op == 'h63);
    endfunction

    function automatic logic model_reads_rs2(input logic [31:0] ins);
        int op;
        op = int'(ins[6:0]);
        return (op == 'h33) || (op == 'h23) || (op == 'h63);
    endfunction

    function automatic logic [59:0] model_ctrl(input logic v, input logic [31:0] ins);
        int op;
        int imm;
        logic [1:0] aop;
        logic [5:0] ctl;
        logic [4:0] r2;
        logic [4:0] rd;
        logic f7;
        op  = int'(ins[6:0]);
        imm = 0;
        r2  = 5'd0;
        rd  = 5'd0;
        f7  = 1'b0;
        if (op == 'h33) begin
            aop = 2'd2; ctl = 6'b000100; r2 = ins[24:20]; rd = ins[11:7]; f7 = ins[30];
        end else if (op == 'h13) begin
            aop = 2'd2; ctl = 6'b100100; rd = ins[11:7];
            imm = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
        end else if (op == 'h03) begin
            aop = 2'd0; ctl = 6'b110110; rd = ins[11:7];
            imm = int'(ins[30:20]) - (ins[31] ? 2048 : 0);
        end else if (op == 'h23) begin
            aop = 2'd0; ctl = 6'b101000; r2 = ins[24:20];
            imm = int'(ins[11:7]) + 32 * int'(ins[30:25]) - (ins[31] ? 2048 : 0);
        end else if (op == 'h63) begin
            aop = 2'd1; ctl = 6'b000001; r2 = ins[24:20];
            imm = 2 * int'(ins[11:8]) + 32 * int'(ins[30:25]) + (ins[7] ? 2048 : 0)
                  - (ins[31] ? 4096 : 0);
        end else begin
            return 60'd0;
        end
        return {v, aop, ins[14:12], f7, ctl, ins[19:15], r2, rd, 32'(imm)};
    endfunction

    // A valid load in EX writing a nonzero register that the ID instruction reads.
    function automatic logic model_stall(input logic v, input logic [31:0] ins, input logic f);
        logic [4:0] prd;
        logic       pload;
        pload = m_vec[59] & m_vec[51];
        prd   = m_vec[36:32];
        if (!v || !model_legal(ins) || f || !pload || prd == 5'd0) return 1'b0;
        return (prd == ins[19:15]) || (model_reads_rs2(ins) && prd == ins[24:20]);
    endfunction

    task automatic set_inputs(input logic v, input logic [31:0] ins, input logic h,
                              input logic f);
        id_valid = v;
        id_instr = ins;
        hold     = h;
        flush    = f;
    endtask

    task automatic advance();
        logic st;
        st = model_stall(id_valid, id_instr, flush);
        if (flush) begin
            m_vec = '0;
            m_ill = 1'b0;
        end else if (hold) begin
            m_vec = m_vec;
        end else if (st) begin
            m_vec = '0;
            m_ill = 1'b0;
        end else begin
            m_vec = model_ctrl(id_valid, id_instr);
            m_ill = id_valid & ~model_legal(id_instr);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_inputs(1'b1, 32'h002081B3, 1'b0, 1'b0);
        m_vec = '0;
        m_ill = 1'b0;
        #12;
        tests_run++;
        if (obs !== 60'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
        end
        rst = 1'b0;
        #1;
        advance();
        tests_run++;
        if (obs !== model_ctrl(1'b1, 32'h002081B3) || ex_valid !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL first_load_after_reset: got %h expected %h", obs,
                     model_ctrl(1'b1, 32'h002081B3));
        end
    endtask

    task automatic test_decode();
        logic [31:0] vec [5];
        vec[0] = 32'h002081B3;
        vec[1] = 32'h402081B3;
        vec[2] = 32'hFFF00293;
        vec[3] = 32'h0041A423;
        vec[4] = 32'h00208463;
        for (int i = 0; i < 5; i++) begin
            set_inputs(1'b1, vec[i], 1'b0, 1'b0);
            advance();
            tests_run++;
            if (obs !== m_vec) begin
                tests_failed++;
                $display("[TB] FAIL decode_%0d: instr %h got %h expected %h", i, vec[i], obs,
                         m_vec);
            end
        end
        // Re-apply the fixed vectors and pin the headline field values from the spec.
        set_inputs(1'b1, 32'h002081B3, 1'b0, 1'b0);
        advance();
        tests_run++;
        if (obs !== {1'b1, 2'b10, 3'b000, 1'b0, 6'b000100, 5'd1, 5'd2, 5'd3, 32'd0}) begin
            tests_failed++;
            $display("[TB] FAIL add_fields: got %h", obs);
        end
        set_inputs(1'b1, 32'h402081B3, 1'b0, 1'b0);
        advance();
        tests_run++;
        if (ex_funct7 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sub_funct7: got %b expected 1", ex_funct7);
        end
        set_inputs(1'b1, 32'hFFF00293, 1'b0, 1'b0);
        advance();
        tests_run++;
        if (ex_imm !== 32'hFFFFFFFF || ex_alu_src !== 1'b1 || ex_funct7 !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL addi_fields: imm %h src %b f7 %b", ex_imm, ex_alu_src,
                     ex_funct7);
        end
        set_inputs(1'b1, 32'h00208463, 1'b0, 1'b0);
        advance();
        tests_run++;
        if (ex_alu_op !== 2'b01 || ex_branch !== 1'b1 || ex_imm !== 32'd8) begin
            tests_failed++;
            $display("[TB] FAIL beq_fields: op %b br %b imm %h", ex_alu_op, ex_branch, ex_imm);
        end
    endtask

    task automatic test_load_use();
        set_inputs(1'b1, 32'h0080A203, 1'b0, 1'b0);
        advance();
        set_inputs(1'b1, 32'h002202B3, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (stall_req !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL load_use_stall: got %b expected 1", stall_req);
        end
        advance();
        tests_run++;
        if (obs !== 60'd0) begin
            tests_failed++;
            $display("[TB] FAIL load_use_bubble: got %h expected 0", obs);
        end
        tests_run++;
        if (stall_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_use_release: got %b expected 0", stall_req);
        end
        advance();
        tests_run++;
        if (obs !== model_ctrl(1'b1, 32'h002202B3)) begin
            tests_failed++;
            $display("[TB] FAIL load_use_replay: got %h expected %h", obs,
                     model_ctrl(1'b1, 32'h002202B3));
        end
        set_inputs(1'b1, 32'h0080A003, 1'b0, 1'b0);
        advance();
        set_inputs(1'b1, 32'h002002B3, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (stall_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL load_x0_no_stall: got %b expected 0", stall_req);
        end
        set_inputs(1'b1, 32'h0080A203, 1'b0, 1'b0);
        advance();
        set_inputs(1'b1, 32'h002202B3, 1'b0, 1'b1);
        #1;
        tests_run++;
        if (stall_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL flush_masks_stall: got %b expected 0", stall_req);
        end
        advance();
    endtask

    task automatic test_hold_flush();
        logic [59:0] held;
        set_inputs(1'b1, 32'h00208463, 1'b0, 1'b0);
        advance();
        held = model_ctrl(1'b1, 32'h00208463);
        for (int i = 0; i < 3; i++) begin
            set_inputs(1'b1, 32'h002081B3 + 32'(i << 7), 1'b1, 1'b0);
            advance();
            tests_run++;
            if (obs !== held) begin
                tests_failed++;
                $display("[TB] FAIL hold_stable_%0d: got %h expected %h", i, obs, held);
            end
        end
        set_inputs(1'b1, 32'h002081B3, 1'b1, 1'b1);
        advance();
        tests_run++;
        if (obs !== 60'd0) begin
            tests_failed++;
            $display("[TB] FAIL flush_over_hold: got %h expected 0", obs);
        end
        set_inputs(1'b1, 32'h002081B3, 1'b0, 1'b0);
        advance();
        set_inputs(1'b1, 32'h402081B3, 1'b1, 1'b0);
        advance();
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (obs !== 60'd0 || stall_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_mid_hold: got %h stall %b expected 0", obs,
                     stall_req);
        end
        #1;
        rst = 1'b0;
        m_vec = '0;
        m_ill = 1'b0;
        set_inputs(1'b0, 32'd0, 1'b0, 1'b0);
        advance();
    endtask

    task automatic test_illegal();
        set_inputs(1'b1, 32'h00002F83, 1'b0, 1'b0);
        advance();
        set_inputs(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
        #1;
        tests_run++;
        if (stall_req !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL illegal_no_stall: got %b expected 0", stall_req);
        end
        advance();
        tests_run++;
        if (obs !== 60'd0) begin
            tests_failed++;
            $display("[TB] FAIL illegal_bubble: got %h expected 0", obs);
        end
`ifdef ILLEGAL_INSTR_EN
        tests_run++;
        if (ex_illegal !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL illegal_flag: got %b expected 1", ex_illegal);
        end
`endif
        set_inputs(1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
        advance();
`ifdef ILLEGAL_INSTR_EN
        tests_run++;
        if (ex_illegal !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL illegal_flag_clear: got %b expected 0", ex_illegal);
        end
`endif
    endtask

    task automatic test_random();
        logic [6:0]  ops [6];
        logic [31:0] ins;
        logic        v;
        logic        h;
        logic        f;
        logic        st;
        int          errs;
        ops[0] = 7'h33; ops[1] = 7'h13; ops[2] = 7'h03;
        ops[3] = 7'h23; ops[4] = 7'h63; ops[5] = 7'h7F;
        errs = 0;
        ins  = 32'h00000013;
        st   = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!st) begin
                ins        = $urandom;
                ins[6:0]   = ops[$urandom_range(0, 5)];
                ins[19:15] = 5'($urandom_range(0, 3));
                ins[24:20] = 5'($urandom_range(0, 3));
                ins[11:7]  = 5'($urandom_range(0, 3));
            end
            v = ($urandom_range(0, 7) != 0);
            h = ($urandom_range(0, 7) == 0);
            f = ($urandom_range(0, 9) == 0);
            set_inputs(v, ins, h, f);
            #1;
            st = model_stall(v, ins, f);
            tests_run++;
            if (stall_req !== st) begin
                tests_failed++;
                errs++;
                if (errs < 10)
                    $display("[TB] FAIL rand_stall cycle %0d: got %b expected %b", c,
                             stall_req, st);
            end
            advance();
            tests_run++;
            if (obs !== m_vec) begin
                tests_failed++;
                errs++;
                if (errs < 10)
                    $display("[TB] FAIL rand_ctrl cycle %0d: got %h expected %h", c, obs, m_vec);
            end
`ifdef ILLEGAL_INSTR_EN
            tests_run++;
            if (ex_illegal !== m_ill) begin
                tests_failed++;
                errs++;
                if (errs < 10)
                    $display("[TB] FAIL rand_illegal cycle %0d: got %b expected %b", c,
                             ex_illegal, m_ill);
            end
`endif
        end
    endtask

    initial begin
        set_inputs(1'b0, 32'd0, 1'b0, 1'b0);
        rst = 1'b1;
        test_reset();
        test_decode();
        test_load_use();
        test_hold_flush();
        test_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
